// File: rtl/bayer_to_draw_point.sv
// Bins each 2x2 Bayer quad (G1,R / B,G2) of the sensor stream into one RGB12
// draw-point write; one line of {G1,R} pairs is buffered across the even row.
module bayer_to_draw_point #(
  parameter int         LINE_WIDTH   = 640,
  parameter int         FRAME_HEIGHT = 480,
  parameter logic [8:0] X_OFFSET     = 9'd0,
  parameter logic [8:0] Y_OFFSET     = 9'd0
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1Enable,
  input  logic        piul1FrameValid,
  input  logic        piul1LineValid,
  input  logic        piul1PixelValid,
  input  logic [11:0] piul12PixelData,
  output logic        poul1Update,
  output logic [8:0]  poul9PosX,
  output logic [8:0]  poul9PosY,
  output logic [11:0] poul12Rgb12Data,
  output logic        poul1FrameDone,
  output logic [7:0]  poul8FrameCount,
  output logic        poul1OverflowErr,
  output logic [1:0]  poul2FsmState
);

  localparam int         HALF_W = LINE_WIDTH / 2;
  localparam int         AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [10:0] LW    = 11'(LINE_WIDTH);
  localparam logic [10:0] FH    = 11'(FRAME_HEIGHT);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        fv_q, lv_q;
  logic [10:0] col_q, col_d, row_q, row_d;
  logic [11:0] g1_q, g1_d, b_q, b_d;
  logic [23:0] rd_q;
  logic [23:0] line_mem [HALF_W];
  logic        upd_q, upd_d, done_q, done_d, ovf_q, ovf_d;
  logic [8:0]  posx_q, posx_d, posy_q, posy_d;
  logic [11:0] rgb_q, rgb_d;
  logic [7:0]  count_q, count_d;
  logic        wr_en, rd_en, pix, in_range;
  logic [AW-1:0] addr;
  logic [12:0] g_sum;

  // Upstream has no ready: a pixel is taken whenever FV&LV&PV is high, and an
  // Update is a single-cycle strobe the sink must always absorb.
  assign pix      = piul1FrameValid & piul1LineValid & piul1PixelValid;
  assign in_range = (col_q < LW) && (row_q < FH);
  assign addr     = col_q[AW:1];
  assign g_sum    = {1'b0, rd_q[23:12]} + {1'b0, piul12PixelData};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    g1_d    = g1_q;
    b_d     = b_q;
    upd_d   = 1'b0;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    posx_d  = posx_q;
    posy_d  = posy_q;
    rgb_d   = rgb_q;
    count_d = count_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      WAIT_LOW: if (!piul1FrameValid) state_d = WAIT_SOF;
      WAIT_SOF: begin
        if (piul1FrameValid && !fv_q) begin
          state_d = piul1Enable ? ACTIVE : WAIT_LOW;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ACTIVE: begin
        if (pix) begin
          if (in_range) begin
            col_d = col_q + 11'd1;
            if (!row_q[0]) begin
              if (!col_q[0]) g1_d = piul12PixelData;
              else           wr_en = 1'b1;
            end else if (!col_q[0]) begin
              b_d   = piul12PixelData;
              rd_en = 1'b1;
            end else begin
              upd_d  = 1'b1;
              posx_d = col_q[9:1] + X_OFFSET;
              posy_d = row_q[9:1] + Y_OFFSET;
              rgb_d  = {rd_q[11:8], g_sum[12:9], b_q[11:8]};
            end
          end else begin
            ovf_d = 1'b1;
          end
        end
        // Line end is applied before frame end when both edges coincide.
        if (lv_q && !piul1LineValid) begin
          col_d = '0;
          if (row_q < FH) row_d = row_q + 11'd1;
        end
        if (fv_q && !piul1FrameValid) begin
          done_d  = 1'b1;
          count_d = count_q + 8'd1;
          state_d = WAIT_LOW;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge piul1Clock) begin
    if (wr_en) line_mem[addr] <= {g1_q, piul12PixelData};
    if (rd_en) rd_q <= line_mem[addr];
  end

  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state_q <= WAIT_LOW;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      g1_q    <= '0;
      b_q     <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      posx_q  <= '0;
      posy_q  <= '0;
      rgb_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fv_q    <= piul1FrameValid;
      lv_q    <= piul1LineValid;
      col_q   <= col_d;
      row_q   <= row_d;
      g1_q    <= g1_d;
      b_q     <= b_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      posx_q  <= posx_d;
      posy_q  <= posy_d;
      rgb_q   <= rgb_d;
      count_q <= count_d;
    end
  end

  assign poul1Update      = upd_q;
  assign poul9PosX        = posx_q;
  assign poul9PosY        = posy_q;
  assign poul12Rgb12Data  = rgb_q;
  assign poul1FrameDone   = done_q;
  assign poul8FrameCount  = count_q;
  assign poul1OverflowErr = ovf_q;
  assign poul2FsmState    = state_q;

endmodule

// File: tb/tb_bayer_to_draw_point.sv
// Bench for bayer_to_draw_point: two instances (no offset / offset 510,5)
// share one 4x2 sensor stream; expected points are queued as pixels are driven.
module tb_bayer_to_draw_point;

  localparam int LW = 4;
  localparam int FH = 2;

  logic        clk = 1'b0;
  logic        rst, en, fv, lv, pv;
  logic [11:0] data;

  logic        upd_a, done_a, ovf_a, upd_b, done_b, ovf_b;
  logic [8:0]  x_a, y_a, x_b, y_b;
  logic [11:0] rgb_a, rgb_b;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  st_a, st_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_n = 0;

  logic [61:0] exp_a_q[$];
  logic [61:0] exp_b_q[$];
  logic [11:0] pix [0:1][0:5];
  logic [11:0] m_g1 [0:1];
  logic [11:0] m_r  [0:1];
  logic [11:0] m_b;

  bayer_to_draw_point #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .X_OFFSET(9'd0), .Y_OFFSET(9'd0)) u_dut_a (
    .piul1Clock(clk), .piul1Reset(rst), .piul1Enable(en), .piul1FrameValid(fv),
    .piul1LineValid(lv), .piul1PixelValid(pv), .piul12PixelData(data),
    .poul1Update(upd_a), .poul9PosX(x_a), .poul9PosY(y_a), .poul12Rgb12Data(rgb_a),
    .poul1FrameDone(done_a), .poul8FrameCount(cnt_a), .poul1OverflowErr(ovf_a),
    .poul2FsmState(st_a));

  bayer_to_draw_point #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .X_OFFSET(9'd510), .Y_OFFSET(9'd5)) u_dut_b (
    .piul1Clock(clk), .piul1Reset(rst), .piul1Enable(en), .piul1FrameValid(fv),
    .piul1LineValid(lv), .piul1PixelValid(pv), .piul12PixelData(data),
    .poul1Update(upd_b), .poul9PosX(x_b), .poul9PosY(y_b), .poul12Rgb12Data(rgb_b),
    .poul1FrameDone(done_b), .poul8FrameCount(cnt_b), .poul1OverflowErr(ovf_b),
    .poul2FsmState(st_b));

  // Clock / cycle counter
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on every Update, check point and its arrival cycle.
  always @(negedge clk) begin
    logic [61:0] e;
    if (done_a) done_n++;
    if (upd_a) begin
      if (exp_a_q.size() == 0) chk("upd_a_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_a_q.pop_front();
        chk("pt_a", {2'b0, x_a, y_a, rgb_a}, {2'b0, e[29:0]});
        chk("lat_a", 32'(cyc), e[61:30]);
      end
    end
    if (upd_b) begin
      if (exp_b_q.size() == 0) chk("upd_b_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_b_q.pop_front();
        chk("pt_b", {2'b0, x_b, y_b, rgb_b}, {2'b0, e[29:0]});
        chk("lat_b", 32'(cyc), e[61:30]);
      end
    end
  end

  task automatic begin_frame();
    fv = 1'b0; lv = 1'b0; pv = 1'b0;
    cycle(); cycle();
    fv = 1'b1;
    cycle();
  endtask

  task automatic drive_row(input int r, input int n, input bit cap, input bit gap);
    logic [12:0] g;
    logic [11:0] p, rgb;
    lv = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (gap) begin
        pv = 1'b0; data = 12'($urandom_range(0, 4095));
        cycle(); cycle();
      end
      p = pix[r][c];
      pv = 1'b1; data = p;
      if (cap && c < LW && r < FH) begin
        if (r % 2 == 0) begin
          if (c % 2 == 0) m_g1[c/2] = p;
          else            m_r[c/2]  = p;
        end else if (c % 2 == 0) begin
          m_b = p;
        end else begin
          g   = {1'b0, m_g1[c/2]} + {1'b0, p};
          rgb = {m_r[c/2][11:8], g[12:9], m_b[11:8]};
          exp_a_q.push_back({32'(cyc + 1), 9'(c/2), 9'(r/2), rgb});
          exp_b_q.push_back({32'(cyc + 1), 9'(c/2 + 510), 9'(r/2 + 5), rgb});
        end
      end
      cycle();
    end
    pv = 1'b0; data = '0;
  endtask

  task automatic run_frame(input int ncols, input bit cap, input bit gap, input bit together);
    begin_frame();
    for (int r = 0; r < FH; r++) begin
      drive_row(r, ncols, cap, gap);
      if (r == FH - 1 && together) begin
        lv = 1'b0; fv = 1'b0;
        cycle();
      end else begin
        lv = 1'b0;
        cycle(); cycle();
      end
    end
    fv = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic fill_random(input int ncols);
    for (int r = 0; r < FH; r++)
      for (int c = 0; c < ncols; c++)
        pix[r][c] = 12'($urandom_range(0, 4095));
  endtask

  task automatic fill_basic();
    pix[0][0] = 12'h800; pix[0][1] = 12'hF00; pix[0][2] = 12'h100; pix[0][3] = 12'h200;
    pix[1][0] = 12'hA00; pix[1][1] = 12'h800; pix[1][2] = 12'h300; pix[1][3] = 12'h300;
  endtask

  initial begin
    int d0;
    logic [7:0] c0;
    rst = 1'b1; en = 1'b1; fv = 1'b0; lv = 1'b0; pv = 1'b0; data = '0;
    repeat (3) cycle();
    chk("rst_upd", 32'(upd_a), 32'd0);
    chk("rst_pos", {14'd0, x_a, y_a}, 32'd0);
    chk("rst_rgb", 32'(rgb_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    chk("rst_ovf", 32'(ovf_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'd0);
    rst = 1'b0;
    cycle();

    // Directed frame from known values, then random frames
    fill_basic();
    d0 = done_n;
    run_frame(4, 1'b1, 1'b0, 1'b0);
    chk("basic_done_pulses", 32'(done_n - d0), 32'd1);
    chk("basic_cnt", 32'(cnt_a), 32'd1);
    chk("basic_cnt_b", 32'(cnt_b), 32'd1);
    chk("basic_ovf", 32'(ovf_a), 32'd0);
    chk("idle_state", 32'(st_a), 32'd1);
    for (int k = 0; k < 2; k++) begin
      fill_random(4);
      run_frame(4, 1'b1, 1'b0, 1'b0);
    end
    chk("rand_cnt", 32'(cnt_a), 32'd3);

    // Over-long lines
    fill_random(6);
    run_frame(6, 1'b1, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf_a), 32'd1);
    chk("ovf_set_b", 32'(ovf_b), 32'd1);
    fill_basic();
    run_frame(4, 1'b1, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(ovf_a), 32'd1);
    chk("ovf_cnt", 32'(cnt_a), 32'd5);

    // Reset mid-frame, released with FrameValid still high
    fill_random(4);
    d0 = done_n;
    begin_frame();
    drive_row(0, 4, 1'b1, 1'b0);
    lv = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (3) cycle();
    chk("mid_rst_pos", {14'd0, x_a, y_a}, 32'd0);
    chk("mid_rst_rgb", 32'(rgb_a), 32'd0);
    chk("mid_rst_cnt", 32'(cnt_a), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    cycle();
    drive_row(1, 4, 1'b0, 1'b0);
    lv = 1'b0;
    cycle();
    fv = 1'b0;
    repeat (4) cycle();
    chk("mid_rst_no_done", 32'(done_n - d0), 32'd0);
    chk("mid_rst_cnt_hold", 32'(cnt_a), 32'd0);
    fill_random(4);
    run_frame(4, 1'b1, 1'b0, 1'b0);
    chk("after_rst_cnt", 32'(cnt_a), 32'd1);

    // Enable low at SOF, raised mid-frame
    fill_random(4);
    d0 = done_n;
    c0 = cnt_a;
    en = 1'b0;
    begin_frame();
    drive_row(0, 4, 1'b0, 1'b0);
    lv = 1'b0;
    cycle();
    en = 1'b1;
    drive_row(1, 4, 1'b0, 1'b0);
    lv = 1'b0;
    cycle();
    fv = 1'b0;
    repeat (4) cycle();
    chk("en_off_no_done", 32'(done_n - d0), 32'd0);
    chk("en_off_cnt", 32'(cnt_a), 32'(c0));
    run_frame(4, 1'b1, 1'b0, 1'b0);
    chk("en_on_cnt", 32'(cnt_a), 32'(c0 + 8'd1));

    // Coincident LV/FV fall, gap-free then gapped with the same pixels
    fill_random(4);
    d0 = done_n;
    run_frame(4, 1'b1, 1'b0, 1'b1);
    chk("together_done", 32'(done_n - d0), 32'd1);
    d0 = done_n;
    run_frame(4, 1'b1, 1'b1, 1'b1);
    chk("gap_done", 32'(done_n - d0), 32'd1);
    chk("gap_cnt", 32'(cnt_a), 32'(c0 + 8'd3));

    repeat (4) cycle();
    chk("exp_left_a", 32'(exp_a_q.size()), 32'd0);
    chk("exp_left_b", 32'(exp_b_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
